// File: rtl/guess_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | guess_pkg: constants and types shared by the button conditioner and   |
// | the guessing-game FSM.                                                |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package guess_pkg;

  localparam int N_BTN = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } btn_state_t;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [N_BTN-1:0] lowest_one(input logic [N_BTN-1:0] v);
    return v & (~v + N_BTN'(1));
  endfunction

  function automatic logic multi_hot(input logic [N_BTN-1:0] v);
    return (v & (v - N_BTN'(1))) != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce: one button channel -- synchroniser, debounce counter,   |
// | accepted (stable) level and registered rising-edge detect.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_prev_q, stable_prev_d;

  always_comb begin
    sync1_d       = raw;
    sync2_d       = sync1_q;
    cnt_d         = cnt_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    // Any sample agreeing with the accepted level restarts the run.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~stable_prev_q;

endmodule
`default_nettype wire

// File: rtl/guess_btn_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | guess_btn_cond: four debounced buttons arbitrated into single-cycle,  |
// | one-hot press pulses for the guessing-game FSM.                       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module guess_btn_cond
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] b,
  output logic             held,
  output logic             rejected
);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] rise;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

  btn_state_t       state_q, state_d;
  logic [N_BTN-1:0] b_q, b_d;
  logic             rejected_q, rejected_d;

  always_comb begin
    state_d    = state_q;
    b_d        = '0;
    rejected_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|rise) begin
          b_d        = lowest_one(rise);
          rejected_d = multi_hot(rise);
          state_d    = HELD;
        end
      end
      HELD: begin
        // A rising channel is itself stable-high, so a new press keeps us HELD.
        if (|rise) begin
          rejected_d = 1'b1;
        end
        if (stable == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      b_q        <= '0;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      rejected_q <= rejected_d;
    end
  end

  assign b        = b_q;
  assign rejected = rejected_q;
  assign held     = (state_q == HELD);

endmodule
`default_nettype wire

// File: tb/tb_guess_btn_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_guess_btn_cond: directed self-checking bench, DEBOUNCE_CYCLES = 4. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_guess_btn_cond;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] b;
  logic       held;
  logic       rejected;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  guess_btn_cond #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .b       (b),
    .held    (held),
    .rejected(rejected)
  );

  // n counts edges from the one that first samples a new btn_raw value (n=1),
  // so an accepted press shows b at n=7 and a release drops held at n_rel+6.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    btn_raw = 4'b1111;
    repeat (3) step();
    n_cmp++; if (b !== 4'b0000) begin n_err++; $display("FAIL reset_b b=%b exp=0000", b); end
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL reset_held held=%b exp=0", held); end
    n_cmp++; if (rejected !== 1'b0) begin n_err++; $display("FAIL reset_rej rejected=%b exp=0", rejected); end
    btn_raw = 4'b0000;
    reset = 1'b1;
    repeat (8) step();
    n_cmp++; if (b !== 4'b0000 || held !== 1'b0 || rejected !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle b=%b held=%b rej=%b exp=0000/0/0", b, held, rejected);
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_b;
    logic exp_h;
    for (int n = 1; n <= 30; n++) begin
      btn_raw = (n <= 20) ? 4'b0001 : 4'b0000;
      step();
      exp_b = (n == 7) ? 4'b0001 : 4'b0000;
      exp_h = (n >= 7 && n <= 26);
      n_cmp++; if (b !== exp_b) begin n_err++; $display("FAIL clean_b n=%0d b=%b exp=%b", n, b, exp_b); end
      n_cmp++; if (held !== exp_h) begin n_err++; $display("FAIL clean_held n=%0d held=%b exp=%b", n, held, exp_h); end
      n_cmp++; if (rejected !== 1'b0) begin n_err++; $display("FAIL clean_rej n=%0d rejected=%b exp=0", n, rejected); end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_b;
    logic exp_h;
    for (int n = 1; n <= 30; n++) begin
      // high,high,low,low,high,high,low,low,high,high then held high (settles at n=9)
      btn_raw = (n > 10 || ((n - 1) / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
      step();
      exp_b = (n == 15) ? 4'b0100 : 4'b0000;
      exp_h = (n >= 15);
      n_cmp++; if (b !== exp_b) begin n_err++; $display("FAIL bounce_b n=%0d b=%b exp=%b", n, b, exp_b); end
      n_cmp++; if (held !== exp_h) begin n_err++; $display("FAIL bounce_held n=%0d held=%b exp=%b", n, held, exp_h); end
    end
    btn_raw = 4'b0000;
    repeat (10) step();
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL bounce_release held=%b exp=0", held); end
  endtask

  task automatic test_glitch();
    for (int n = 1; n <= 15; n++) begin
      btn_raw = (n <= 3) ? 4'b1000 : 4'b0000;
      step();
      n_cmp++; if (b !== 4'b0000) begin n_err++; $display("FAIL glitch_b n=%0d b=%b exp=0000", n, b); end
      n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL glitch_held n=%0d held=%b exp=0", n, held); end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_b;
    logic exp_h, exp_r;
    for (int n = 1; n <= 30; n++) begin
      btn_raw = (n <= 20) ? 4'b0110 : 4'b0000;
      step();
      exp_b = (n == 7) ? 4'b0010 : 4'b0000;
      exp_r = (n == 7);
      exp_h = (n >= 7 && n <= 26);
      n_cmp++; if (b !== exp_b) begin n_err++; $display("FAIL simul_b n=%0d b=%b exp=%b", n, b, exp_b); end
      n_cmp++; if (rejected !== exp_r) begin n_err++; $display("FAIL simul_rej n=%0d rejected=%b exp=%b", n, rejected, exp_r); end
      n_cmp++; if (held !== exp_h) begin n_err++; $display("FAIL simul_held n=%0d held=%b exp=%b", n, held, exp_h); end
    end
  endtask

  task automatic test_overlap();
    logic [3:0] exp_b;
    logic exp_h, exp_r;
    for (int n = 1; n <= 45; n++) begin
      if (n < 11)      btn_raw = 4'b0001;
      else if (n < 25) btn_raw = 4'b1001;
      else if (n < 35) btn_raw = 4'b0000;
      else             btn_raw = 4'b1000;
      step();
      exp_b = (n == 7) ? 4'b0001 : (n == 41) ? 4'b1000 : 4'b0000;
      exp_r = (n == 17);
      exp_h = (n >= 7 && n <= 30) || (n >= 41);
      n_cmp++; if (b !== exp_b) begin n_err++; $display("FAIL overlap_b n=%0d b=%b exp=%b", n, b, exp_b); end
      n_cmp++; if (rejected !== exp_r) begin n_err++; $display("FAIL overlap_rej n=%0d rejected=%b exp=%b", n, rejected, exp_r); end
      n_cmp++; if (held !== exp_h) begin n_err++; $display("FAIL overlap_held n=%0d held=%b exp=%b", n, held, exp_h); end
    end
    btn_raw = 4'b0000;
    repeat (10) step();
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL overlap_release held=%b exp=0", held); end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_b;
    logic exp_h;
    btn_raw = 4'b0001;
    for (int n = 1; n <= 10; n++) begin
      step();
    end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL areset_pre_held held=%b exp=1", held); end
    // Assert reset between clock edges: outputs must clear without an edge.
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (b !== 4'b0000 || held !== 1'b0 || rejected !== 1'b0) begin
      n_err++; $display("FAIL areset_now b=%b held=%b rej=%b exp=0000/0/0", b, held, rejected);
    end
    repeat (3) step();
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL areset_during held=%b exp=0", held); end
    reset = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      exp_b = (n == 7) ? 4'b0001 : 4'b0000;
      exp_h = (n >= 7);
      n_cmp++; if (b !== exp_b) begin n_err++; $display("FAIL areset_b n=%0d b=%b exp=%b", n, b, exp_b); end
      n_cmp++; if (held !== exp_h) begin n_err++; $display("FAIL areset_held n=%0d held=%b exp=%b", n, held, exp_h); end
    end
    btn_raw = 4'b0000;
    repeat (10) step();
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL areset_release held=%b exp=0", held); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_overlap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
